// File: rtl/fetch_decoder_if.sv
// fetch_decoder_if: fetch-byte port and decoded-record port of fetch_decoder.
// The slave modport is the decoder side; the master modport is the
// fetch/execute side that drives bytes and pops records.
`timescale 1ns/1ps
interface fetch_decoder_if #(
  parameter int WIDTH = 16
) ();
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_class;
  logic [1:0]       out_src;
  logic             out_rel_stack;
  logic [2:0]       out_cond;
  logic [WIDTH-1:0] out_rhs;
  logic [1:0]       out_bytes;
  logic [WIDTH-1:0] out_pc;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_valid, out_class, out_src, out_rel_stack,
           out_cond, out_rhs, out_bytes, out_pc
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_valid, out_class, out_src, out_rel_stack,
           out_cond, out_rhs, out_bytes, out_pc
  );
endinterface

// File: rtl/fetch_decoder.sv
// fetch_decoder: byte-serial fetch/decode stage for cora16.
// Assembles one/two-byte instructions, tracks their address, decodes them into
// class/operand records and queues the records in a DEPTH-entry FIFO.
// Optional feature macro: FETCH_DECODER_ILLEGAL_TRAP_EN -- when defined,
// unknown opcodes decode as trap and set the sticky `illegal` flag; when
// undefined, unknown opcodes decode as nop and `illegal` is tied low.
`timescale 1ns/1ps
module fetch_decoder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] flush_pc,
  output logic             illegal,
  fetch_decoder_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
`ifdef FETCH_DECODER_ILLEGAL_TRAP_EN
  localparam logic [4:0] UNKNOWN_CLASS = 5'd2;
`else
  localparam logic [4:0] UNKNOWN_CLASS = 5'd0;
`endif

  typedef struct packed {
    logic [4:0]       cls;
    logic [1:0]       src;
    logic             rel;
    logic [2:0]       cond;
    logic [WIDTH-1:0] rhs;
    logic [1:0]       bytes;
    logic [WIDTH-1:0] pc;
  } rec_t;

  typedef enum logic {S_IDLE = 1'b0, S_HAVE_HI = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [6:0]       r_hi;          // bit7 of a latched hi byte is always 1
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_hi_pc;
  rec_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_count;

  logic             w_full, w_accept, w_push, w_pop, w_unknown;
  logic             w_shr, w_branch;
  logic [14:0]      w_inst;
  logic [3:0]       w_op;
  rec_t             w_dec, w_rec;

  assign w_full        = (r_count == FULL_COUNT);
  assign bus.in_ready  = !rst && !flush && !w_full;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (r_count != '0);
  assign w_pop         = bus.out_valid && bus.out_ready && !flush;

  // Two-byte instruction view: {hi[6:0], byte}; inst[15] is implied 1.
  assign w_inst   = {r_hi, bus.in_data};
  assign w_op     = w_inst[14:11];
  assign w_branch = (w_op == 4'h8) || (w_op == 4'hA);
  // Shift direction comes from the address LSB only for a direct RAM operand.
  assign w_shr    = (w_inst[10] && !w_inst[8]) ? w_inst[0] : w_inst[8];

  // Assembler state register; flush and reset both return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Assembler next state and instruction-complete strobe.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && bus.in_data[7]) begin
          w_state_next = S_HAVE_HI;
        end else if (w_accept) begin
          w_push = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_HAVE_HI: begin
        if (w_accept) begin
          w_state_next = S_IDLE;
          w_push       = 1'b1;
        end else begin
          w_state_next = S_HAVE_HI;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      w_push = w_push && w_accept;
    end
  end

  // Byte address counter and latched first byte of a two-byte instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_hi    <= 7'd0;
      r_hi_pc <= '0;
    end else if (flush) begin
      r_pc    <= flush_pc;
      r_hi    <= 7'd0;
    end else if (w_accept) begin
      r_pc <= r_pc + WIDTH'(1'b1);
      if (r_state == S_IDLE && bus.in_data[7]) begin
        r_hi    <= bus.in_data[6:0];
        r_hi_pc <= r_pc;
      end
    end
  end

  // Decode the instruction completed by the current byte.
  always_comb begin
    w_dec      = '0;
    w_unknown  = 1'b0;
    w_dec.cond = bus.in_data[2:0];
    if (r_state == S_IDLE) begin
      w_dec.bytes = 2'd1;
      w_dec.pc    = r_pc;
      case (bus.in_data)
        8'h0C:   begin w_dec.cls = 5'd24; w_dec.src = 2'd3; end
        8'h0D:   begin w_dec.cls = 5'd25; w_dec.src = 2'd3; end
        8'h10:   w_dec.cls = 5'd12;
        8'h3E:   w_dec.cls = 5'd13;
        8'h3F:   w_dec.cls = 5'd14;
        8'h44:   begin w_dec.cls = 5'd15; w_dec.src = 2'd1; end
        default: begin
          if (bus.in_data <= 8'h0B) w_dec.cls = bus.in_data[4:0];
          else                      w_unknown = 1'b1;
        end
      endcase
    end else begin
      w_dec.bytes = 2'd2;
      w_dec.pc    = r_hi_pc;
      case (w_op)
        4'h0:    w_dec.cls = 5'd15;
        4'h1:    w_dec.cls = 5'd17;
        4'h2:    w_dec.cls = 5'd16;
        4'h3:    w_dec.cls = 5'd18;
        4'h4:    w_dec.cls = 5'd19;
        4'h5:    w_dec.cls = 5'd20;
        4'h6:    w_dec.cls = 5'd21;
        4'h7:    w_dec.cls = w_shr ? 5'd23 : 5'd22;
        4'h8:    w_dec.cls = 5'd24;
        4'hA:    w_dec.cls = 5'd25;
        4'hE:    w_dec.cls = 5'd26;
        default: w_unknown = 1'b1;
      endcase
      if (w_branch) begin
        w_dec.rhs = {{(WIDTH-11){w_inst[10]}}, w_inst[10:0]};
      end else if (w_inst[10]) begin
        w_dec.src = w_inst[8] ? 2'd2 : 2'd1;
        w_dec.rel = w_inst[9];
        if (w_op == 4'h7 && !w_inst[8]) w_dec.rhs = WIDTH'({w_inst[7:1], 1'b0});
        else                            w_dec.rhs = WIDTH'(w_inst[7:0]);
      end else if (w_inst[9]) begin
        // Data-byte form: only the flag survives, in the operand MSB.
        w_dec.rhs[WIDTH-1] = 1'b1;
      end else if (w_inst[8]) begin
        w_dec.rhs = WIDTH'({w_inst[7:0], 8'h00});
      end else begin
        w_dec.rhs = WIDTH'(w_inst[7:0]);
      end
    end
  end

  // Unknown opcodes collapse to a bare nop/trap record.
  always_comb begin
    w_rec = w_dec;
    if (w_unknown) begin
      w_rec.cls = UNKNOWN_CLASS;
      w_rec.src = 2'd0;
      w_rec.rel = 1'b0;
      w_rec.rhs = '0;
    end else begin
      w_rec = w_dec;
    end
  end

  // Decoded-record FIFO; flush empties it and ignores any pop that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_rec;
        r_wr        <= r_wr + AW'(1'b1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1'b1);
      if (w_push && !w_pop)      r_count <= r_count + (AW + 1)'(1'b1);
      else if (!w_push && w_pop) r_count <= r_count - (AW + 1)'(1'b1);
      else                       r_count <= r_count;
    end
  end

  assign bus.out_class     = r_mem[r_rd].cls;
  assign bus.out_src       = r_mem[r_rd].src;
  assign bus.out_rel_stack = r_mem[r_rd].rel;
  assign bus.out_cond      = r_mem[r_rd].cond;
  assign bus.out_rhs       = r_mem[r_rd].rhs;
  assign bus.out_bytes     = r_mem[r_rd].bytes;
  assign bus.out_pc        = r_mem[r_rd].pc;

`ifdef FETCH_DECODER_ILLEGAL_TRAP_EN
  logic r_illegal;
  // Sticky unknown-opcode flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_illegal <= 1'b0;
    else if (w_push && w_unknown)  r_illegal <= 1'b1;
    else                           r_illegal <= r_illegal;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule
